// File: rtl/fpu_result_buffer.sv
// rtl/fpu_result_buffer.sv - 2-entry FPU adder result FIFO with per-entry NaN/inf/ovf/unf flags
// Sticky flag accumulation is built only when FPU_RESULT_STICKY_EN is defined.
module fpu_result_buffer #(
    parameter int X = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [X-1:0] in_result,
    input  logic         in_overflow,
    input  logic         in_underflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [X-1:0] out_result,
    output logic [3:0]   out_flags,
    output logic [3:0]   sticky_flags,
    input  logic         flag_clr,
    output logic [1:0]   count
);
    localparam int EW = (X == 32) ? 8 : 11;
    localparam int FW = X - 1 - EW;

    logic [X-1:0] mem_result [2];
    logic [3:0]   mem_flags  [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;
    logic         exp_ones;
    logic         frac_nz;
    logic [3:0]   in_flags;

    // Handshake decisions use only registered occupancy, so a full buffer
    // refuses a push even when the head is popped in the same cycle.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign exp_ones = &in_result[X-2 -: EW];
    assign frac_nz  = |in_result[FW-1:0];
    assign in_flags = {exp_ones && !frac_nz, exp_ones && frac_nz, in_underflow, in_overflow};

    assign out_result = mem_result[rd_ptr];
    assign out_flags  = mem_flags[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_result[0] <= '0;
            mem_result[1] <= '0;
            mem_flags[0]  <= '0;
            mem_flags[1]  <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= in_result;
                mem_flags[wr_ptr]  <= in_flags;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FPU_RESULT_STICKY_EN
    // A push in the clear cycle is ORed after the clear so its flags survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 4'b0000;
        end else begin
            sticky_flags <= (flag_clr ? 4'b0000 : sticky_flags) | (push ? in_flags : 4'b0000);
        end
    end
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign sticky_flags    = 4'b0000;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb/tb_fpu_result_buffer.sv - scoreboard bench for fpu_result_buffer (X=32 and X=64 instances)
module tb_fpu_result_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_overflow, in_underflow, out_ready, flag_clr;
    logic [31:0] in_result;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags, sticky_flags;
    logic [1:0]  count;

    logic        d_in_valid, d_in_ready, d_out_valid;
    logic [63:0] d_in_result, d_out_result;
    logic [3:0]  d_out_flags, d_sticky_flags;
    logic [1:0]  d_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } ent_t;
    ent_t sb[$];

    always #5 clk = ~clk;

    fpu_result_buffer #(.X(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .sticky_flags(sticky_flags), .flag_clr(flag_clr),
        .count(count)
    );

    fpu_result_buffer #(.X(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_result(d_in_result), .in_overflow(1'b0), .in_underflow(1'b0),
        .out_valid(d_out_valid), .out_ready(1'b0), .out_result(d_out_result),
        .out_flags(d_out_flags), .sticky_flags(d_sticky_flags), .flag_clr(1'b0),
        .count(d_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_flags(input logic [31:0] r, input logic ov, input logic uf);
        logic all_ones;
        logic nz;
        all_ones = (r[30:23] == 8'hFF);
        nz       = (r[22:0] != 23'd0);
        return {all_ones && !nz, all_ones && nz, uf, ov};
    endfunction

    // Called right after a falling edge; samples handshakes 1ns before the rising edge.
    task automatic drive(input logic v, input logic [31:0] r, input logic ov, input logic uf,
                         input logic ordy, input logic clr);
        ent_t e;
        in_valid = v; in_result = r; in_overflow = ov; in_underflow = uf;
        out_ready = ordy; flag_clr = clr;
        #4;
        if (in_valid && in_ready) begin
            e.r = r;
            e.f = model_flags(r, ov, uf);
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_result", out_result, e.r);
                check("sb_flags", out_flags, e.f);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; in_result = 0; in_overflow = 0; in_underflow = 0;
        out_ready = 0; flag_clr = 0; d_in_valid = 0; d_in_result = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_sticky", sticky_flags, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single word, one-cycle latency
        drive(1, 32'h3F800000, 0, 0, 1, 0);
        check("lat_out_valid", out_valid, 1);
        check("lat_out_result", out_result, 32'h3F800000);
        check("lat_out_flags", out_flags, 4'b0000);
        check("lat_count1", count, 1);
        drive(0, 0, 0, 0, 1, 0);
        check("lat_count0", count, 0);

        // fill, refused third push (even with a pop), drain
        drive(1, 32'h40000000, 0, 0, 0, 0);
        drive(1, 32'h40400000, 0, 0, 0, 0);
        check("full_count", count, 2);
        check("full_in_ready", in_ready, 0);
        check("hold_result", out_result, 32'h40000000);
        drive(1, 32'h40800000, 0, 0, 1, 0);
        check("refused_count", count, 1);
        check("second_head", out_result, 32'h40400000);
        drive(0, 0, 0, 0, 1, 0);
        check("drain_count", count, 0);
        check("drain_sb_empty", sb.size(), 0);

        // classification and sticky accumulation
        drive(1, 32'h7FC00000, 0, 0, 0, 0);
        check("nan_flags", out_flags, 4'b0100);
        drive(1, 32'h7F800000, 1, 0, 1, 0);
        check("inf_ovf_flags", out_flags, 4'b1001);
`ifdef FPU_RESULT_STICKY_EN
        check("sticky_accum", sticky_flags, 4'b1101);
`else
        check("sticky_tied", sticky_flags, 4'b0000);
`endif
        drive(0, 0, 0, 0, 1, 0);

        // clear with simultaneous push
        drive(1, 32'h3F800000, 0, 1, 0, 1);
`ifdef FPU_RESULT_STICKY_EN
        check("sticky_clr_push", sticky_flags, 4'b0010);
`else
        check("sticky_clr_tied", sticky_flags, 4'b0000);
`endif
        check("uf_flags", out_flags, 4'b0010);

        // simultaneous push and pop at count 1
        drive(1, 32'hC0000000, 0, 0, 1, 0);
        check("pp_count", count, 1);
        check("pp_result", out_result, 32'hC0000000);
        drive(0, 0, 0, 0, 1, 0);

        // inputs ignored without push
        drive(0, 32'h7FC00000, 1, 1, 1, 0);
        check("nopush_count", count, 0);
        check("nopush_valid", out_valid, 0);
`ifdef FPU_RESULT_STICKY_EN
        check("nopush_sticky", sticky_flags, 4'b0010);
`endif

        // double precision NaN
        d_in_valid = 1; d_in_result = 64'h7FF8000000000000;
        @(negedge clk);
        d_in_valid = 0;
        check("d64_result", d_out_result, 64'h7FF8000000000000);
        check("d64_flags", d_out_flags, 4'b0100);
        check("d64_count", d_count, 1);

        // asynchronous reset while full
        drive(1, 32'h7F800000, 1, 0, 0, 0);
        drive(1, 32'h7FC00000, 0, 0, 0, 0);
        check("pre_rst_count", count, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_valid", out_valid, 0);
        check("async_sticky", sticky_flags, 0);
        check("async_in_ready", in_ready, 1);
        check("async_d64_count", d_count, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 32'h12345678, 0, 0, 0, 0);
        check("post_rst_result", out_result, 32'h12345678);
        drive(0, 0, 0, 0, 1, 0);
        check("post_rst_count", count, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_result_buffer.md
FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 SHALL have parameter X, default 32, meaning operand width (32 single, 64 double); exponent width 8 when X==32, else 11.
REQ-002 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream adder result valid.
REQ-005 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-006 SHALL have port in_result  input  X  adder out word (sign|exponent|fraction).
REQ-007 SHALL have port in_overflow  input  1  adder overflow for in_result.
REQ-008 SHALL have port in_underflow  input  1  adder underflow for in_result.
REQ-009 SHALL have port out_valid  output  1  head entry valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts head.
REQ-011 SHALL have port out_result  output  X  head entry result.
REQ-012 SHALL have port out_flags  output  4  head flags: [0] overflow, [1] underflow, [2] NaN, [3] infinity.
REQ-013 SHALL have port sticky_flags  output  4  accumulated flags, same bit order.
REQ-014 SHALL have port flag_clr  input  1  synchronous clear of sticky_flags.
REQ-015 SHALL have port count  output  2  occupancy, 0..2.

Function
REQ-016 SHALL be a 2-entry FIFO of {result, flags}, 1-bit read and write pointers, each wrapping 1->0.
REQ-017 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count != 2) from registered state; a push offered while full is dropped upstream-held, even if a pop occurs that cycle.
REQ-019 SHALL drive out_valid = (count != 0); out_result/out_flags from the read-pointer entry, combinational from registers.
REQ-020 SHALL give 1-cycle latency: word pushed at edge N appears on out_result after edge N when the FIFO was empty.
REQ-021 SHALL, on simultaneous push and pop with count 1, keep count at 1 and present the new entry after the edge.
REQ-022 SHALL hold out_result/out_flags stable while out_valid && !out_ready.
REQ-023 SHALL classify at push: NaN = exponent all ones and fraction nonzero; infinity = exponent all ones and fraction zero; overflow/underflow copied from inputs.
REQ-024 SHALL set overflow flag bit of an entry also when classification says infinity only if in_overflow is 1 (no inference).
REQ-025 SHALL update sticky_flags <= (flag_clr ? 0 : sticky_flags) | pushed flags; a push in the same cycle as flag_clr survives the clear.
REQ-026 SHALL ignore in_result/in_overflow/in_underflow when no push occurs.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear pointers, count, sticky_flags and entry storage to 0; outputs: in_ready 1, out_valid 0, out_result 0, out_flags 0, sticky_flags 0, count 0.
REQ-028 SHALL discard in-flight entries when reset asserts mid-operation; first push after release lands in entry 0.

Configuration
REQ-029 SHALL compile sticky flag logic only when FPU_RESULT_STICKY_EN is defined; REQ-025 applies.
REQ-030 SHALL, without FPU_RESULT_STICKY_EN, tie sticky_flags to 4'b0000 and ignore flag_clr; per-entry out_flags unaffected.

Verification
REQ-031 SHALL verify: reset, push 32'h3F800000 flags 0, out_ready 1 -> out_valid next cycle, out_result 32'h3F800000, out_flags 4'b0000, count 1 then 0.
REQ-032 SHALL verify: out_ready 0, push 32'h40000000 then 32'h40400000 -> count 2, in_ready 0; third push 32'h40800000 refused; drain yields 40000000 then 40400000.
REQ-033 SHALL verify: push 32'h7FC00000 -> out_flags 4'b0100; push 32'h7F800000 with in_overflow 1 -> out_flags 4'b1001; sticky_flags 4'b1101.
REQ-034 SHALL verify: flag_clr 1 same cycle as push with in_underflow 1 -> sticky_flags 4'b0010 afterwards.
REQ-035 SHALL verify: count 1, simultaneous push 32'hC0000000 and pop -> count 1, out_result 32'hC0000000; with X=64 push 64'h7FF8000000000000 -> out_flags 4'b0100.
REQ-036 SHALL verify: rst_n low while count 2 -> count 0, out_valid 0, sticky_flags 0 immediately, without a clock edge.
